replace_plru_mp: RTL and testbench

REPLACE_PLRU_MP -- requirements
Module: replace_plru_mp

---
 rtl/replace_plru_mp.sv | 128 ++++++++++++
 tb/tb_replace_plru_mp.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/replace_plru_mp.sv
// ============================================================================
// Module   : replace_plru_mp
// Purpose  : Multi-port tree-PLRU / LFSR victim selection for a set-assoc cache
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module replace_plru_mp #(
  parameter int DEPTH      = 256,
  parameter int WAY_NUM    = 4,
  parameter int READ_PORT  = 1,
  parameter int MODE       = 0,
  parameter int WAY_WIDTH  = $clog2(WAY_NUM),
  parameter int ADDR_WIDTH = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [READ_PORT-1:0]                  hit_en,
  input  logic [READ_PORT-1:0][WAY_WIDTH-1:0]   hit_way,
  input  logic [READ_PORT-1:0][ADDR_WIDTH-1:0]  hit_index,
  input  logic                                  miss_en,
  input  logic [ADDR_WIDTH-1:0]                 miss_index,
  input  logic [WAY_NUM-1:0]                    way_valid,
  output logic [WAY_WIDTH-1:0]                  miss_way
);

  localparam int NODES = WAY_NUM - 1;

  logic [NODES-1:0]     r_tree [DEPTH];
  logic [NODES-1:0]     w_next [DEPTH];
  logic [15:0]          r_lfsr;
  logic                 w_free_found;
  logic [WAY_WIDTH-1:0] w_free_way;
  logic [WAY_WIDTH-1:0] w_full_victim;

  // Point every node on the path of way w away from w.
  function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] t,
                                             input logic [WAY_WIDTH-1:0] w);
    logic [NODES-1:0] r;
    int node;
    r    = t;
    node = 0;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      r[node] = ~w[WAY_WIDTH-1-l];
      node    = 2 * node + 1 + int'(w[WAY_WIDTH-1-l]);
    end
    return r;
  endfunction

  function automatic logic [WAY_WIDTH-1:0] walk(input logic [NODES-1:0] t);
    logic [WAY_WIDTH-1:0] w;
    int node;
    w    = '0;
    node = 0;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      w[WAY_WIDTH-1-l] = t[node];
      node             = 2 * node + 1 + int'(t[node]);
    end
    return w;
  endfunction

  // Same-set accesses chain in port order with the miss last, so later ones win shared nodes.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      w_next[s] = r_tree[s];
      for (int p = 0; p < READ_PORT; p++) begin
        if (hit_en[p] && (hit_index[p] == ADDR_WIDTH'(s))) begin
          w_next[s] = touch(w_next[s], hit_way[p]);
        end
      end
      if (miss_en && (miss_index == ADDR_WIDTH'(s))) begin
        w_next[s] = touch(w_next[s], miss_way);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        r_tree[s] <= '0;
      end
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        r_tree[s] <= w_next[s];
      end
    end
  end

  // Fibonacci LFSR, taps 16/14/13/11.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= 16'h0001;
    end else if (miss_en) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  always_comb begin
    w_free_found = 1'b0;
    w_free_way   = '0;
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      if (!way_valid[i]) begin
        w_free_found = 1'b1;
        w_free_way   = WAY_WIDTH'(i);
      end
    end
  end

  generate
    if (MODE == 1) begin : g_mode_lfsr
      assign w_full_victim = r_lfsr[WAY_WIDTH-1:0];
    end else begin : g_mode_plru
      logic [NODES-1:0] w_sel_tree;
      if (DEPTH == (1 << ADDR_WIDTH)) begin : g_depth_full
        assign w_sel_tree = r_tree[miss_index];
      end else begin : g_depth_partial
        // Unpopulated indices read as a freshly reset set.
        assign w_sel_tree = (int'(miss_index) < DEPTH) ? r_tree[miss_index] : '0;
      end
      assign w_full_victim = walk(w_sel_tree);
    end
  endgenerate

  assign miss_way = w_free_found ? w_free_way : w_full_victim;

endmodule

`default_nettype wire

// File: tb/tb_replace_plru_mp.sv
// ============================================================================
// Module   : tb_replace_plru_mp
// Purpose  : Scoreboard bench for replace_plru_mp, PLRU and LFSR instances
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_replace_plru_mp;

  localparam int DEPTH = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       hit_en;
  logic [1:0][1:0]  hit_way;
  logic [1:0][3:0]  hit_index;
  logic             miss_en;
  logic [3:0]       miss_index;
  logic [3:0]       way_valid;
  logic [1:0]       miss_way_plru;
  logic [1:0]       miss_way_rand;

  always #5 clk = ~clk;

  replace_plru_mp #(.DEPTH(DEPTH), .WAY_NUM(4), .READ_PORT(2), .MODE(0)) u_plru (
    .clk(clk), .rst(rst), .hit_en(hit_en), .hit_way(hit_way), .hit_index(hit_index),
    .miss_en(miss_en), .miss_index(miss_index), .way_valid(way_valid), .miss_way(miss_way_plru)
  );

  replace_plru_mp #(.DEPTH(DEPTH), .WAY_NUM(4), .READ_PORT(2), .MODE(1)) u_rand (
    .clk(clk), .rst(rst), .hit_en(hit_en), .hit_way(hit_way), .hit_index(hit_index),
    .miss_en(miss_en), .miss_index(miss_index), .way_valid(way_valid), .miss_way(miss_way_rand)
  );

  // Reference model: per set, root / left-pair / right-pair pointers (1 = go right).
  logic [2:0]  m_tree [2][16];
  logic [15:0] m_lfsr;

  logic [1:0] exp_plru_q [$];
  logic [1:0] exp_rand_q [$];
  string      tag_q [$];
  int         checks = 0;
  int         passes = 0;

  function automatic void model_reset();
    for (int m = 0; m < 2; m++)
      for (int s = 0; s < 16; s++) m_tree[m][s] = 3'b000;
    m_lfsr = 16'h0001;
  endfunction

  function automatic logic [1:0] model_victim(input int m, input logic [3:0] idx,
                                              input logic [3:0] vv);
    logic [2:0] t;
    for (int i = 0; i < 4; i++) if (!vv[i]) return 2'(i);
    if (m == 1) return m_lfsr[1:0];
    t = m_tree[0][idx];
    if (!t[0]) return t[1] ? 2'd1 : 2'd0;
    return t[2] ? 2'd3 : 2'd2;
  endfunction

  function automatic void model_touch(input int m, input logic [3:0] idx, input logic [1:0] w);
    logic [2:0] t;
    if (int'(idx) >= DEPTH) return;
    t = m_tree[m][idx];
    t[0] = (w < 2);
    if (w < 2) t[1] = (w == 0);
    else       t[2] = (w == 2);
    m_tree[m][idx] = t;
  endfunction

  task automatic cyc(input logic r, input logic [1:0] he,
                     input logic [1:0] w0, input logic [3:0] i0,
                     input logic [1:0] w1, input logic [3:0] i1,
                     input logic me, input logic [3:0] mi, input logic [3:0] vv,
                     input string tag);
    logic [1:0] v [2];
    @(negedge clk);
    rst = r; hit_en = he; hit_way[0] = w0; hit_index[0] = i0;
    hit_way[1] = w1; hit_index[1] = i1; miss_en = me; miss_index = mi; way_valid = vv;
    if (!r) model_reset();
    for (int m = 0; m < 2; m++) v[m] = model_victim(m, mi, vv);
    exp_plru_q.push_back(v[0]);
    exp_rand_q.push_back(v[1]);
    tag_q.push_back(tag);
    if (r) begin
      for (int m = 0; m < 2; m++) begin
        if (he[0]) model_touch(m, i0, w0);
        if (he[1]) model_touch(m, i1, w1);
        if (me)    model_touch(m, mi, v[m]);
      end
      if (me) m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    end
  endtask

  task automatic idle(input logic [3:0] mi, input string tag);
    cyc(1'b1, 2'b00, 2'd0, 4'd0, 2'd0, 4'd0, 1'b0, mi, 4'hF, tag);
  endtask

  // Monitor: output is presented every cycle; compare well after inputs settle.
  initial begin
    logic [1:0] e0, e1;
    string      t;
    forever begin
      @(negedge clk);
      #2;
      while (exp_plru_q.size() > 0) begin
        e0 = exp_plru_q.pop_front();
        e1 = exp_rand_q.pop_front();
        t  = tag_q.pop_front();
        checks++;
        if (miss_way_plru === e0) passes++;
        else $display("FAIL %s plru: miss_way=%0d expected %0d", t, miss_way_plru, e0);
        checks++;
        if (miss_way_rand === e1) passes++;
        else $display("FAIL %s lfsr: miss_way=%0d expected %0d", t, miss_way_rand, e1);
      end
    end
  end

  initial begin
    logic [1:0] he, w0, w1;
    logic [3:0] i0, i1, mi, vv;
    logic       me;
    rst = 1'b0; hit_en = '0; hit_way = '0; hit_index = '0;
    miss_en = 1'b0; miss_index = '0; way_valid = 4'hF;
    model_reset();

    cyc(1'b0, 2'b00, 2'd0, 4'd0, 2'd0, 4'd0, 1'b0, 4'd5, 4'hF, "reset_hold");
    idle(4'd5, "after_reset");
    cyc(1'b1, 2'b01, 2'd0, 4'd5, 2'd0, 4'd0, 1'b0, 4'd5, 4'hF, "hit_s5_w0");
    idle(4'd5, "progress_1");
    cyc(1'b1, 2'b01, 2'd2, 4'd5, 2'd0, 4'd0, 1'b0, 4'd5, 4'hF, "hit_s5_w2");
    idle(4'd5, "progress_2");

    cyc(1'b0, 2'b00, 2'd0, 4'd0, 2'd0, 4'd0, 1'b0, 4'd5, 4'hF, "reset_2");
    cyc(1'b1, 2'b11, 2'd1, 4'd5, 2'd3, 4'd5, 1'b0, 4'd5, 4'hF, "dual_hit_s5");
    idle(4'd5, "dual_order");
    idle(4'd6, "other_set");
    cyc(1'b1, 2'b00, 2'd0, 4'd0, 2'd0, 4'd0, 1'b0, 4'd5, 4'b1011, "invalid_pref");
    cyc(1'b1, 2'b00, 2'd0, 4'd0, 2'd0, 4'd0, 1'b0, 4'd6, 4'b0000, "invalid_all");

    cyc(1'b1, 2'b01, 2'd2, 4'd7, 2'd0, 4'd0, 1'b1, 4'd7, 4'hF, "hit_and_miss_s7");
    idle(4'd7, "miss_last");

    cyc(1'b1, 2'b01, 2'd1, 4'd12, 2'd3, 4'd14, 1'b1, 4'd12, 4'hF, "out_of_range");
    idle(4'd12, "oor_unchanged");

    cyc(1'b0, 2'b00, 2'd0, 4'd0, 2'd0, 4'd0, 1'b0, 4'd3, 4'hF, "reset_3");
    idle(4'd3, "lfsr_start");
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 2'b00, 2'd0, 4'd0, 2'd0, 4'd0, 1'b1, 4'd3, 4'hF, "lfsr_step");
    idle(4'd3, "lfsr_after");

    for (int k = 0; k < 400; k++) begin
      he = 2'($urandom);
      w0 = 2'($urandom);
      w1 = 2'($urandom);
      i0 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 7));
      i1 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 7));
      mi = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 7));
      vv = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
      me = ($urandom_range(0, 2) == 0);
      cyc(1'b1, he, w0, i0, w1, i1, me, mi, vv, "random");
    end

    // Reset asserted between rising edges while traffic is still being driven.
    for (int k = 0; k < DEPTH; k++)
      cyc(1'b0, 2'($urandom), 2'($urandom), 4'($urandom_range(0, 9)), 2'($urandom),
          4'($urandom_range(0, 9)), 1'b1, 4'(k), 4'hF, "midstream_reset");
    for (int k = 0; k < 6; k++)
      cyc(1'b1, 2'b00, 2'd0, 4'd0, 2'd0, 4'd0, 1'b1, 4'($urandom_range(0, 9)), 4'hF,
          "lfsr_restart");
    idle(4'd0, "final");

    repeat (2) @(negedge clk);
    #4;
    checks++;
    if (exp_plru_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: pending=%0d expected 0", exp_plru_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
